// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter and access sequencer between the fetch port (0) and the
// load/store port (1) for the shared 16-bit memory, with a programmable wait-state count.
module mem_arbiter #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [15:0] addr0,
    input  logic [15:0] addr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [15:0] rdata0,
    output logic [15:0] rdata1,
    output logic [15:0] mem_address,
    output logic [15:0] mem_data_in,
    output logic        mem_write_enable,
    input  logic [15:0] mem_data_out,
    output logic        busy,
    output logic        grant_id
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t     state, state_nx;
    logic [3:0] cnt;
    logic       lat_we;
    logic       last_grant;
    logic       win;
    logic       start;
    logic       last_cycle;
    // On a tie the port that did not win last time gets the bus.
    assign win        = (req0 && req1) ? ~last_grant : req1;
    assign start      = state == IDLE && (req0 || req1);
    assign last_cycle = state == ACCESS && cnt == 4'd0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end
    always_comb begin
        state_nx         = state;
        busy             = state != IDLE;
        mem_write_enable = last_cycle && lat_we;
        ack0             = state == RESP && !grant_id;
        ack1             = state == RESP && grant_id;
        case (state)
            IDLE:    state_nx = start ? ACCESS : IDLE;
            ACCESS:  state_nx = last_cycle ? RESP : ACCESS;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= 4'd0;
            lat_we      <= 1'b0;
            last_grant  <= 1'b1;
            grant_id    <= 1'b0;
            mem_address <= 16'h0000;
            mem_data_in <= 16'h0000;
            rdata0      <= 16'h0000;
            rdata1      <= 16'h0000;
        end else begin
            if (start) begin
                grant_id    <= win;
                last_grant  <= win;
                lat_we      <= win ? we1 : we0;
                mem_address <= win ? addr1 : addr0;
                mem_data_in <= win ? wdata1 : wdata0;
                cnt         <= 4'(WAIT_CYCLES - 1);
            end else if (state == ACCESS && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (last_cycle && !lat_we && !grant_id)
                rdata0 <= mem_data_out;
            if (last_cycle && !lat_we && grant_id)
                rdata1 <= mem_data_out;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: drives two arbiters (WAIT_CYCLES 1 and 3) against a transaction-level
// reference that schedules grants from request times and round-robin order.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;
    logic        req0[2], req1[2], we0[2], we1[2];
    logic [15:0] addr0[2], addr1[2], wdata0[2], wdata1[2];
    logic        ack0[2], ack1[2], mwe[2], busy[2], gid[2];
    logic [15:0] rdata0[2], rdata1[2], maddr[2], mdin[2], mdout[2];
    logic [7:0]  mem[2][65536];
    logic [7:0]  rmem[65536];
    int          ecount = 0;
    int          passed = 0, total = 0;
    logic        lg[2], gidm[2];
    logic [15:0] rdm[2][2], mam[2], mdm[2];

    typedef struct {bit w; logic [15:0] a; logic [15:0] d; int gap;} op_t;
    typedef struct {int g; bit p; bit w; logic [15:0] a; logic [15:0] d; logic [15:0] rd;} gnt_t;

    mem_arbiter #(.WAIT_CYCLES(1)) dut_w1 (
        .clk(clk), .rst_n(rst_n), .req0(req0[0]), .req1(req1[0]), .we0(we0[0]), .we1(we1[0]),
        .addr0(addr0[0]), .addr1(addr1[0]), .wdata0(wdata0[0]), .wdata1(wdata1[0]),
        .ack0(ack0[0]), .ack1(ack1[0]), .rdata0(rdata0[0]), .rdata1(rdata1[0]),
        .mem_address(maddr[0]), .mem_data_in(mdin[0]), .mem_write_enable(mwe[0]),
        .mem_data_out(mdout[0]), .busy(busy[0]), .grant_id(gid[0]));
    mem_arbiter #(.WAIT_CYCLES(3)) dut_w3 (
        .clk(clk), .rst_n(rst_n), .req0(req0[1]), .req1(req1[1]), .we0(we0[1]), .we1(we1[1]),
        .addr0(addr0[1]), .addr1(addr1[1]), .wdata0(wdata0[1]), .wdata1(wdata1[1]),
        .ack0(ack0[1]), .ack1(ack1[1]), .rdata0(rdata0[1]), .rdata1(rdata1[1]),
        .mem_address(maddr[1]), .mem_data_in(mdin[1]), .mem_write_enable(mwe[1]),
        .mem_data_out(mdout[1]), .busy(busy[1]), .grant_id(gid[1]));

    // Little-endian byte memory behind each arbiter.
    assign mdout[0] = {mem[0][maddr[0] + 16'd1], mem[0][maddr[0]]};
    assign mdout[1] = {mem[1][maddr[1] + 16'd1], mem[1][maddr[1]]};
    always @(posedge clk) begin
        ecount <= ecount + 1;
        for (int i = 0; i < 2; i++)
            if (mwe[i]) begin
                mem[i][maddr[i]] = mdin[i][7:0];
                mem[i][maddr[i] + 16'd1] = mdin[i][15:8];
            end
    end

    function automatic logic [68:0] outs(input int i);
        return {ack0[i], ack1[i], busy[i], mwe[i], gid[i], rdata0[i], rdata1[i], maddr[i], mdin[i]};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_req(input int i, input bit p, input bit r, input bit w,
                           input logic [15:0] a, input logic [15:0] d);
        if (p) begin
            req1[i] = r; we1[i] = w; addr1[i] = a; wdata1[i] = d;
        end else begin
            req0[i] = r; we0[i] = w; addr0[i] = a; wdata0[i] = d;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            lg[i] = 1'b1; gidm[i] = 1'b0; mam[i] = '0; mdm[i] = '0;
            rdm[i][0] = '0; rdm[i][1] = '0;
        end
    endtask

    task automatic do_reset();
        for (int i = 0; i < 2; i++) begin
            set_req(i, 1'b0, 1'b0, 1'b0, '0, '0);
            set_req(i, 1'b1, 1'b0, 1'b0, '0, '0);
        end
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        model_reset();
    endtask

    // One directed access; returns per-cycle bit vectors indexed by cycle after the grant edge.
    task automatic access(input int i, input bit p, input bit w, input logic [15:0] a,
                          input logic [15:0] d, input int n,
                          output logic [15:0] av0, output logic [15:0] av1, output logic [15:0] bv,
                          output logic [15:0] wv, output logic [15:0] rd, output logic [15:0] wa,
                          output logic [15:0] wd);
        int wc;
        logic [15:0] er;
        wc = i ? 3 : 1;
        er = {mem[i][a + 16'd1], mem[i][a]};
        av0 = '0; av1 = '0; bv = '0; wv = '0; rd = '0; wa = '0; wd = '0;
        set_req(i, p, 1'b1, w, a, d);
        @(posedge clk);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            av0[k] = ack0[i]; av1[k] = ack1[i]; bv[k] = busy[i]; wv[k] = mwe[i];
            if (mwe[i]) begin
                wa = maddr[i]; wd = mdin[i];
            end
            if (ack0[i] || ack1[i]) rd = p ? rdata1[i] : rdata0[i];
            if (k == wc + 1) begin
                @(posedge clk);
                #1;
                set_req(i, p, 1'b0, w, a, d);
            end
        end
        tick(1);
        lg[i] = p; gidm[i] = p; mam[i] = a; mdm[i] = d;
        if (!w) rdm[i][p] = er;
    endtask

    task automatic drive_port(input int i, input bit p, input op_t q[$]);
        int c;
        foreach (q[k]) begin
            tick(q[k].gap);
            set_req(i, p, 1'b1, q[k].w, q[k].a, q[k].d);
            c = 0;
            do begin
                @(negedge clk);
                c++;
            end while (!(p ? ack1[i] : ack0[i]) && c < 100);
            if (c >= 100) begin
                total++;
                $display("FAIL ack_timeout inst%0d port%0d: no ack within %0d cycles, required one", i, p, c);
            end
            tick(1);
            set_req(i, p, 1'b0, q[k].w, q[k].a, q[k].d);
        end
    endtask

    // Plans random accesses, schedules the expected grants, then runs and checks every cycle.
    task automatic scenario(input int i, input int n0, input int n1, input int gapmax, input bit wr);
        op_t q0[$], q1[$];
        gnt_t gq[$];
        op_t o;
        int wc, nx0, nx1, v0, v1, f, t, s, s_end, bad;
        bit last, e0, e1, p, ea0, ea1, eb, ew, eg;
        logic [15:0] er0, er1, ema, emd, rd;
        wc = i ? 3 : 1;
        for (int k = 0; k < n0 + n1; k++) begin
            o.w = wr ? 1'($urandom_range(0, 1)) : 1'b0;
            o.a = 16'h0100 + 16'($urandom_range(0, 15));
            o.d = 16'($urandom);
            o.gap = int'($urandom_range(0, gapmax));
            if (k < n0) q0.push_back(o);
            else q1.push_back(o);
        end
        foreach (rmem[k]) rmem[k] = mem[i][k];
        s = ecount; f = s + 1; last = lg[i]; nx0 = 0; nx1 = 0; v0 = 0; v1 = 0;
        if (n0 > 0) v0 = s + q0[0].gap + 1;
        if (n1 > 0) v1 = s + q1[0].gap + 1;
        while (nx0 < n0 || nx1 < n1) begin
            t = nx0 >= n0 ? v1 : nx1 >= n1 ? v0 : (v0 < v1 ? v0 : v1);
            if (t < f) t = f;
            e0 = nx0 < n0 && v0 <= t;
            e1 = nx1 < n1 && v1 <= t;
            p = (e0 && e1) ? !last : !e0;
            o = p ? q1[nx1] : q0[nx0];
            rd = o.w ? 16'h0 : {rmem[o.a + 16'd1], rmem[o.a]};
            gq.push_back('{t, p, o.w, o.a, o.d, rd});
            if (o.w) begin
                rmem[o.a] = o.d[7:0];
                rmem[o.a + 16'd1] = o.d[15:8];
            end
            last = p;
            f = t + wc + 2;
            if (p) begin
                nx1++;
                if (nx1 < n1) v1 = f + q1[nx1].gap;
            end else begin
                nx0++;
                if (nx0 < n0) v0 = f + q0[nx0].gap;
            end
        end
        s_end = gq.size() > 0 ? gq[$].g + wc + 1 : s;
        fork
            drive_port(i, 1'b0, q0);
            drive_port(i, 1'b1, q1);
            do begin
                @(negedge clk);
                ea0 = 0; ea1 = 0; eb = 0; ew = 0; eg = gidm[i];
                er0 = rdm[i][0]; er1 = rdm[i][1]; ema = mam[i]; emd = mdm[i];
                foreach (gq[k]) if (gq[k].g <= ecount) begin
                    eg = gq[k].p; ema = gq[k].a; emd = gq[k].d;
                    if (ecount <= gq[k].g + wc) eb = 1;
                    if (gq[k].w && ecount == gq[k].g + wc - 1) ew = 1;
                    if (ecount == gq[k].g + wc) begin
                        if (gq[k].p) ea1 = 1;
                        else ea0 = 1;
                    end
                    if (!gq[k].w && ecount >= gq[k].g + wc) begin
                        if (gq[k].p) er1 = gq[k].rd;
                        else er0 = gq[k].rd;
                    end
                end
                total++;
                if (outs(i) !== {ea0, ea1, eb, ew, eg, er0, er1, ema, emd})
                    $display("FAIL cycle inst%0d edge %0d: got %h want %h", i, ecount, outs(i),
                             {ea0, ea1, eb, ew, eg, er0, er1, ema, emd});
                else passed++;
            end while (ecount < s_end);
        join
        bad = 0;
        foreach (rmem[k]) if (rmem[k] !== mem[i][k]) bad++;
        total++;
        if (bad != 0) $display("FAIL memory inst%0d: %0d bytes differ, required 0", i, bad);
        else passed++;
        if (gq.size() > 0) begin
            lg[i] = gq[$].p; gidm[i] = gq[$].p; mam[i] = gq[$].a; mdm[i] = gq[$].d;
        end
        foreach (gq[k]) if (!gq[k].w) rdm[i][gq[k].p] = gq[k].rd;
        tick(1);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            set_req(i, 1'b0, 1'b0, 1'b0, '0, '0);
            set_req(i, 1'b1, 1'b0, 1'b0, '0, '0);
        end
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (outs(i) !== '0) $display("FAIL reset_outputs inst%0d: got %h want 0", i, outs(i));
            else passed++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        model_reset();
    endtask

    task automatic test_single_read();
        logic [15:0] av0, av1, bv, wv, rd, wa, wd;
        mem[0][16'h0010] = 8'hEF;
        mem[0][16'h0011] = 8'hBE;
        access(0, 1'b0, 1'b0, 16'h0010, 16'h0000, 4, av0, av1, bv, wv, rd, wa, wd);
        total += 5;
        if (av0 !== 16'h0004) $display("FAIL single_read ack0: got %h want 0004", av0); else passed++;
        if (bv !== 16'h0006) $display("FAIL single_read busy: got %h want 0006", bv); else passed++;
        if (av1 !== 16'h0000 || wv !== 16'h0000)
            $display("FAIL single_read ack1/we: got %h/%h want 0/0", av1, wv); else passed++;
        if (rd !== 16'hBEEF) $display("FAIL single_read rdata0: got %h want beef", rd); else passed++;
        if (rdata1[0] !== rdm[0][1]) $display("FAIL single_read rdata1: got %h want %h", rdata1[0], rdm[0][1]);
        else passed++;
    endtask

    task automatic test_write_then_read();
        logic [15:0] av0, av1, bv, wv, rd, wa, wd;
        access(0, 1'b1, 1'b1, 16'h0020, 16'h1234, 4, av0, av1, bv, wv, rd, wa, wd);
        total += 4;
        if (wv !== 16'h0002) $display("FAIL write_pulse: got %h want 0002", wv); else passed++;
        if ({wa, wd} !== {16'h0020, 16'h1234}) $display("FAIL write_bus: got %h want 00201234", {wa, wd});
        else passed++;
        if (av1 !== 16'h0004 || av0 !== 16'h0000)
            $display("FAIL write_ack: got ack1 %h ack0 %h want 0004/0000", av1, av0); else passed++;
        access(0, 1'b0, 1'b0, 16'h0020, 16'h0000, 4, av0, av1, bv, wv, rd, wa, wd);
        if (rd !== 16'h1234) $display("FAIL read_after_write: got %h want 1234", rd); else passed++;
    endtask

    task automatic test_wait_states();
        logic [15:0] av0, av1, bv, wv, rd, wa, wd;
        access(1, 1'b0, 1'b1, 16'h0031, 16'hA5A5, 6, av0, av1, bv, wv, rd, wa, wd);
        total += 5;
        if (bv !== 16'h001E) $display("FAIL wait_busy: got %h want 001e", bv); else passed++;
        if (wv !== 16'h0008) $display("FAIL wait_pulse: got %h want 0008", wv); else passed++;
        if (av0 !== 16'h0010 || av1 !== 16'h0000)
            $display("FAIL wait_ack: got ack0 %h ack1 %h want 0010/0000", av0, av1); else passed++;
        if ({wa, wd} !== {16'h0031, 16'hA5A5}) $display("FAIL wait_bus: got %h want 0031a5a5", {wa, wd});
        else passed++;
        if ({mem[1][16'h0032], mem[1][16'h0031]} !== 16'hA5A5)
            $display("FAIL wait_mem: got %h want a5a5", {mem[1][16'h0032], mem[1][16'h0031]}); else passed++;
    endtask

    task automatic test_contention();
        do_reset();
        scenario(0, 4, 4, 0, 1'b0);
    endtask

    task automatic test_lone_requester();
        scenario(0, 0, 4, 0, 1'b0);
    endtask

    task automatic test_reset_mid_write();
        mem[1][16'h0040] = 8'h11;
        mem[1][16'h0041] = 8'h22;
        set_req(1, 1'b0, 1'b1, 1'b1, 16'h0040, 16'hDEAD);
        @(posedge clk);
        repeat (2) @(negedge clk);
        total += 4;
        if (mwe[1] !== 1'b0 || busy[1] !== 1'b1)
            $display("FAIL pre_reset: got we %b busy %b want 0 1", mwe[1], busy[1]); else passed++;
        rst_n = 1'b0;
        #1;
        if (outs(1) !== '0 || outs(0) !== '0)
            $display("FAIL reset_mid_outputs: got %h %h want 0", outs(1), outs(0)); else passed++;
        set_req(1, 1'b0, 1'b0, 1'b0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        if (outs(1) !== '0) $display("FAIL reset_hold: got %h want 0", outs(1)); else passed++;
        if ({mem[1][16'h0041], mem[1][16'h0040]} !== 16'h2211)
            $display("FAIL reset_mem: got %h want 2211", {mem[1][16'h0041], mem[1][16'h0040]}); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        model_reset();
        scenario(1, 1, 1, 0, 1'b0);
    endtask

    task automatic test_random();
        scenario(0, 16, 16, 3, 1'b1);
        scenario(1, 12, 12, 3, 1'b1);
    endtask

    initial begin
        foreach (mem[i, k]) mem[i][k] = 8'($urandom);
        model_reset();
        test_reset();
        test_single_read();
        test_write_then_read();
        test_wait_states();
        test_contention();
        test_lone_requester();
        test_reset_mid_write();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and access sequencer for the shared 16-bit, byte-addressed, little-endian unified memory. It arbitrates between the instruction-fetch port (port 0) and the load/store port (port 1). The winning request drives the memory address, write data and write enable for a programmable number of wait cycles. It then returns registered read data with a one-cycle ack. The block sits between the CPU front/back ends and the memory, and is the only driver of the memory's write enable.

## Interface
Parameters:
- WAIT_CYCLES, 1, cycles the memory access is held before completion; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req0 / req1  input  1  access request from port 0 / port 1.
- we0 / we1  input  1  1 = write, 0 = read; qualified by the port's req.
- addr0 / addr1  input  16  byte address.
- wdata0 / wdata1  input  16  write data.
- ack0 / ack1  output  1  one-cycle completion pulse to port 0 / port 1.
- rdata0 / rdata1  output  16  read data; valid while the matching ack is high, held afterwards.
- mem_address  output  16  to memory address.
- mem_data_in  output  16  to memory write data.
- mem_write_enable  output  1  to memory write enable.
- mem_data_out  input  16  from memory, combinational read data.
- busy  output  1  high whenever the FSM is not in IDLE.
- grant_id  output  1  port owning the current or most recent access.

## Operation
- FSM states and transitions:
  - IDLE -> ACCESS when any req is sampled high.
  - ACCESS -> RESP when the wait counter reaches 0.
  - RESP -> IDLE unconditionally.
- Arbitration happens only in IDLE:
  - Single requester wins.
  - If both request, the port other than last_grant wins (round-robin).
  - last_grant resets to 1, so the first tie after reset goes to port 0.
- On the grant edge:
  - Latch the winner's we, addr and wdata.
  - Set grant_id and last_grant.
  - Load cnt = WAIT_CYCLES-1.
- ACCESS:
  - mem_address and mem_data_in drive the latched values.
  - cnt decrements each cycle.
  - mem_write_enable = (state==ACCESS && cnt==0 && latched_we). It is high exactly one cycle per write.
  - On the edge leaving ACCESS with cnt==0, for a read, mem_data_out is captured into rdata of the granted port only. The other port's rdata is unchanged.
  - For a write, rdata is unchanged.
- RESP: ack of the granted port is high for exactly one cycle. The other ack stays low. ack0 and ack1 are never high together.
- Requester obligations:
  - Hold req, we, addr and wdata stable from assertion until ack is seen.
  - Drop req at the edge ending the ack cycle unless another access is wanted.
  - Inputs sampled outside IDLE are ignored. A req still high in IDLE is a new request.
- Addresses pass through unmodified. No alignment check; odd addresses are legal.
- mem_address and mem_data_in hold their last latched values while idle.
- Reset values: state IDLE, all of the following zero:
  - ack0/1, rdata0/1, busy.
  - mem_address, mem_data_in, mem_write_enable.
  - grant_id, cnt.
- Reset mid-access: mem_write_enable falls immediately (asynchronous). No write or ack completes. The pending request is dropped; the requester must re-request after rst_n releases.

## Timing
- Access latency is measured from the IDLE edge that samples req (edge 0):
  - ACCESS occupies cycles 1..WAIT_CYCLES.
  - ack is high in cycle WAIT_CYCLES+1.
- WAIT_CYCLES=1: req sampled at edge 0, the write pulse is in cycle 1, ack is in cycle 2.
- Throughput: one access per WAIT_CYCLES+2 cycles, including under continuous requests.
- Output sourcing:
  - All outputs are registered, or decoded from registered state only.
  - mem_data_out is the sole combinational input used, and it is sampled at the end of the last ACCESS cycle.
- Write visibility: a write commits at the edge ending its pulse cycle, so a read granted afterwards returns the new data.

## Test plan
- Single read: memory preloaded 0xBEEF at 0x0010. req0=1, we0=0, addr0=0x0010, WAIT_CYCLES=1 -> ack0 high in cycle 2 only, rdata0=0xBEEF, ack1=0, rdata1 unchanged, busy high in cycles 1-2.
- Write then read: port1 writes 0x1234 to 0x0020 -> mem_write_enable high exactly 1 cycle with mem_address=0x0020 and mem_data_in=0x1234, ack1 in the next cycle. A following port-0 read of 0x0020 returns 0x1234.
- Contention: after reset, req0 and req1 held high continuously with distinct addresses -> grants 0,1,0,1..., each ack one cycle wide, every 3 cycles, acks never overlapping.
- Wait states: WAIT_CYCLES=3, write by port 0 -> busy for 4 cycles, mem_write_enable high only in the 3rd ACCESS cycle, ack0 in cycle 4.
- Reset mid-write: rst_n driven low during ACCESS, before the pulse, with WAIT_CYCLES=3 -> mem_write_enable stays 0, memory contents are unchanged, all outputs are zero during reset, and the first tie after release is granted to port 0.
- Lone requester: port 1 issues 4 back-to-back reads while req0=0 -> all 4 served at period WAIT_CYCLES+2, grant_id=1 throughout, ack0 never asserted.
